sys_array_ctrl: RTL

SYS_ARRAY_CTRL -- requirements
Module: sys_array_ctrl

---
 rtl/sys_array_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sys_array_ctrl.sv
// Systolic array pass controller: issues im2col windows under FIFO credit,
// deskews the 16 array columns and returns per-window results in issue order.
module sys_array_ctrl #(
    parameter int NUM_WIN    = 196,
    parameter int BASE_LAT   = 1,
    parameter int FIFO_DEPTH = 32
) (
    input  logic         clk_i,
    input  logic         rst_n,
    input  logic         start_i,
    output logic         win_req_o,
    input  logic         win_vld_i,
    input  logic [215:0] win_data_i,
    output logic [215:0] arr_a_o,
    input  logic [127:0] arr_c_i,
    output logic         res_vld_o,
    input  logic         res_rdy_i,
    output logic [127:0] res_data_o,
    output logic [7:0]   res_idx_o,
    output logic         busy_o,
    output logic         done_o
);
    localparam int STAGES = BASE_LAT + 16;
    localparam int CW     = $clog2(NUM_WIN + 1);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int KW     = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
    typedef struct packed {
        logic [7:0]   idx;
        logic [127:0] data;
    } entry_t;

    state_e          state_q, state_d;
    logic [CW-1:0]   issue_cnt_q, issue_cnt_d, pop_cnt_q, pop_cnt_d;
    logic [KW-1:0]   credit_q, credit_d;
    logic [7:0]      wr_idx_q, wr_idx_d;
    logic [STAGES:0] vld_pipe_q, vld_pipe_d;
    logic [215:0]    arr_a_q, arr_a_d;
    logic            busy_q, busy_d, done_q, done_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    entry_t          mem_q [FIFO_DEPTH];
    entry_t          mem_d [FIFO_DEPTH];
    logic [127:0]    aligned;
    logic            issue, pop, push, empty;

    assign issue     = win_req_o && win_vld_i;
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign push      = vld_pipe_q[STAGES];
    assign pop       = res_vld_o && res_rdy_i;
    assign win_req_o = (state_q == RUN) && (credit_q != '0) && (issue_cnt_q < CW'(NUM_WIN));
    assign res_vld_o = !empty;
    // Gate the read port so stale memory never leaks out after reset.
    assign res_data_o = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]].data;
    assign res_idx_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]].idx;
    assign arr_a_o    = arr_a_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

    // Column k is captured BASE_LAT+k+1 edges after the load and delayed a
    // further 15-k stages, so every column lines up at stage BASE_LAT+16.
    for (genvar k = 0; k < 16; k++) begin : g_col
        localparam int LEN = 16 - k;
        logic [LEN-1:0][7:0] sh_q, sh_d;
        always_comb begin
            sh_d    = sh_q;
            sh_d[0] = arr_c_i[8*k +: 8];
            for (int i = 1; i < LEN; i++) sh_d[i] = sh_q[i-1];
        end
        always_ff @(posedge clk_i) begin
            if (!rst_n) sh_q <= '0;
            else        sh_q <= sh_d;
        end
        assign aligned[8*k +: 8] = sh_q[LEN-1];
    end

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        pop_cnt_d   = pop_cnt_q;
        credit_d    = credit_q;
        wr_idx_d    = wr_idx_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_d       = mem_q;
        arr_a_d     = issue ? win_data_i : '0;
        vld_pipe_d  = {vld_pipe_q[STAGES-1:0], issue};

        if (issue) issue_cnt_d = issue_cnt_q + CW'(1);
        if (pop)   pop_cnt_d   = pop_cnt_q + CW'(1);
        case ({issue, pop})
            2'b10:   credit_d = credit_q - KW'(1);
            2'b01:   credit_d = credit_q + KW'(1);
            default: credit_d = credit_q;
        endcase
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = '{idx: wr_idx_q, data: aligned};
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            wr_idx_d = wr_idx_q + 8'd1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + (AW+1)'(1);

        case (state_q)
            IDLE: if (start_i) begin
                state_d     = RUN;
                issue_cnt_d = '0;
                pop_cnt_d   = '0;
                wr_idx_d    = '0;
            end
            RUN:     if (issue_cnt_d == CW'(NUM_WIN)) state_d = DRAIN;
            DRAIN:   if (pop && pop_cnt_q == CW'(NUM_WIN - 1)) state_d = DONE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            pop_cnt_q   <= '0;
            credit_q    <= KW'(FIFO_DEPTH);
            wr_idx_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            vld_pipe_q  <= '0;
            arr_a_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            pop_cnt_q   <= pop_cnt_d;
            credit_q    <= credit_d;
            wr_idx_q    <= wr_idx_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            vld_pipe_q  <= vld_pipe_d;
            arr_a_q     <= arr_a_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk_i) mem_q <= mem_d;

endmodule
